shared_adder_arb: RTL and testbench

SHARED_ADDER_ARB -- requirements
Module: shared_adder_arb

---
 rtl/shared_adder_arb_pkg.sv | 18 +
 rtl/shared_adder_arb_rr_arbiter.sv | 27 ++
 rtl/shared_adder_arb.sv | 103 ++++++++++
 tb/tb_shared_adder_arb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_adder_arb_pkg.sv
// Shared types, default sizes and helpers for the shared adder with
// round-robin arbitration.
package shared_adder_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NREQ_DEF = 3;
  localparam int W_DEF    = 32;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_adder_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first valid requester found
// starting at (last_grant+1) mod NREQ.
module rr_arbiter
  import shared_adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  // Walk from lowest to highest priority so the last match wins.
  always_comb begin
    grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == ((int'(last_grant) + k) % NREQ) && req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_adder_arb.sv
// One W-bit adder shared by NREQ requesters with a one-entry result register.
// Optional macro ADD_OVF_ZERO_EN: a carry-out forces the sum to zero.
module shared_adder_arb
  import shared_adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  localparam int IDW = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_ovf
);

  state_t         state_reg;
  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W-1:0]   rsp_sum_reg;
  logic           rsp_ovf_reg;

  logic [NREQ-1:0] grant;
  logic            can_accept;
  logic            accept;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum_full;
  logic [W-1:0]    sum_next;
  logic [W-1:0]    a_lane [NREQ];
  logic [W-1:0]    b_lane [NREQ];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // A new add may start when the register is empty or is being drained now.
  assign can_accept = (state_reg == IDLE) || rsp_ready;
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign accept     = |req_ready;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign a_lane[gi] = req_a[gi*W +: W] & {W{req_ready[gi]}};
      assign b_lane[gi] = req_b[gi*W +: W] & {W{req_ready[gi]}};
    end
  endgenerate

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | a_lane[i];
      b_sel = b_sel | b_lane[i];
      if (req_ready[i]) win_id = IDW'(i);
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADD_OVF_ZERO_EN
  assign sum_next = sum_full[W] ? '0 : sum_full[W-1:0];
`else
  assign sum_next = sum_full[W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      rsp_id_reg     <= '0;
      rsp_sum_reg    <= '0;
      rsp_ovf_reg    <= 1'b0;
    end else if (accept) begin
      state_reg      <= HOLD;
      last_grant_reg <= win_id;
      rsp_id_reg     <= win_id;
      rsp_sum_reg    <= sum_next;
      rsp_ovf_reg    <= sum_full[W];
    end else if (state_reg == HOLD && rsp_ready) begin
      state_reg <= IDLE;
    end
  end

  assign rsp_valid = (state_reg == HOLD);
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_shared_adder_arb.sv
// Directed self-checking bench for shared_adder_arb (NREQ=3, W=32).
module tb_shared_adder_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [95:0] req_a;
  logic [95:0] req_b;
  logic [2:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_ovf;

  logic [31:0] a_lane [3];
  logic [31:0] b_lane [3];

  int errors;
  int checks;

  assign req_a = {a_lane[2], a_lane[1], a_lane[0]};
  assign req_b = {b_lane[2], b_lane[1], b_lane[0]};

  shared_adder_arb #(.NREQ(3), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_lane[i] = 32'h0;
      b_lane[i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL reset_rsp_sum got %h want 0", rsp_sum); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf got %b want 0", rsp_ovf); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
    rst_n = 1'b1;
    req_valid = 3'b000;
  endtask

  task automatic test_single();
    // Starts right after reset release: first edge must accept.
    req_valid = 3'b001;
    a_lane[0] = 32'h00000004;
    b_lane[0] = 32'h00400000;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_grant got %b want 001", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    $display("txn single id=%0d sum=%h ovf=%b", rsp_id, rsp_sum, rsp_ovf);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h00400004) begin errors++; $display("FAIL single_rsp_sum got %h want 00400004", rsp_sum); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL single_rsp_ovf got %b want 0", rsp_ovf); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL single_idle_ready got %b want 000", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g   [6];
    logic [1:0]  exp_id  [6];
    logic [31:0] exp_sum [3];
    exp_g   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    exp_sum = '{32'h12, 32'h24, 32'h36};
    // Fresh reset so requester 0 has first priority.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_lane[0] = 32'h11; b_lane[0] = 32'h1;
    a_lane[1] = 32'h22; b_lane[1] = 32'h2;
    a_lane[2] = 32'h33; b_lane[2] = 32'h3;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (req_ready !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_g[k]); end
      @(negedge clk);
      if (k == 5) req_valid = 3'b000;
      $display("txn rr id=%0d sum=%h", rsp_id, rsp_sum);
      checks++; if (rsp_id !== exp_id[k]) begin errors++; $display("FAIL rr_id[%0d] got %0d want %0d", k, rsp_id, exp_id[k]); end
      checks++; if (rsp_sum !== exp_sum[exp_id[k]]) begin errors++; $display("FAIL rr_sum[%0d] got %h want %h", k, rsp_sum, exp_sum[exp_id[k]]); end
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    // last_grant is 2 here, so requester 0 is first.
    req_valid = 3'b001;
    a_lane[0] = 32'h1; b_lane[0] = 32'h2;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_first_grant got %b want 001", req_ready); end
    @(negedge clk);
    req_valid = 3'b010;
    a_lane[1] = 32'h5; b_lane[1] = 32'h6;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", c, rsp_valid); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL bp_id[%0d] got %0d want 0", c, rsp_id); end
      checks++; if (rsp_sum !== 32'h3) begin errors++; $display("FAIL bp_sum[%0d] got %h want 3", c, rsp_sum); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_grant got %b want 010", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    $display("txn bp id=%0d sum=%h", rsp_id, rsp_sum);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_b2b_id got %0d want 1", rsp_id); end
    checks++; if (rsp_sum !== 32'hB) begin errors++; $display("FAIL bp_b2b_sum got %h want b", rsp_sum); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef ADD_OVF_ZERO_EN
    exp_sum = 32'h00000000;
`else
    exp_sum = 32'h00000001;
`endif
    req_valid = 3'b100;
    a_lane[2] = 32'hFFFFFFFF; b_lane[2] = 32'h00000002;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL ovf_grant got %b want 100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    $display("txn ovf id=%0d sum=%h ovf=%b", rsp_id, rsp_sum, rsp_ovf);
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_id got %0d want 2", rsp_id); end
    checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", rsp_ovf); end
    checks++; if (rsp_sum !== exp_sum) begin errors++; $display("FAIL ovf_sum got %h want %h", rsp_sum, exp_sum); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    req_valid = 3'b010;
    a_lane[1] = 32'h7; b_lane[1] = 32'h8;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 3'b000;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mr_hold got %b want 1", rsp_valid); end
    checks++; if (rsp_sum !== 32'hF) begin errors++; $display("FAIL mr_hold_sum got %h want f", rsp_sum); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_async_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("FAIL mr_async_sum got %h want 0", rsp_sum); end
    req_valid = 3'b101;
    a_lane[0] = 32'h100; b_lane[0] = 32'h1;
    a_lane[2] = 32'h200; b_lane[2] = 32'h2;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL mr_ready_in_reset got %b want 000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mr_first_grant got %b want 001", req_ready); end
    @(negedge clk);
    $display("txn mr id=%0d sum=%h", rsp_id, rsp_sum);
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL mr_id0 got %0d want 0", rsp_id); end
    checks++; if (rsp_sum !== 32'h101) begin errors++; $display("FAIL mr_sum0 got %h want 101", rsp_sum); end
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL mr_second_grant got %b want 100", req_ready); end
    @(negedge clk);
    req_valid = 3'b000;
    $display("txn mr id=%0d sum=%h", rsp_id, rsp_sum);
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL mr_id2 got %0d want 2", rsp_id); end
    checks++; if (rsp_sum !== 32'h202) begin errors++; $display("FAIL mr_sum2 got %h want 202", rsp_sum); end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
